bsg_fifo_1r1w_small_mc: RTL
===========================

Name: bsg_fifo_1r1w_small_mc

Overview:
- Multi-channel successor to the single-channel small 1r1w FIFO.
- Holds channels_p independent FIFOs, each els_p deep, with per-channel valid/ready enqueue ports.
- The FIFOs drain through one shared valid/yumi output port under round-robin arbitration. The output carries the channel id, per-channel occupancy and almost-full flags.
- Sits between several producers (e.g. network endpoints) and a single consumer that must see fair service.

Parameters:
- width_p, 16, payload width in bits.
- els_p, 4, entries per channel; any value ≥2, not required to be a power of two.
- channels_p, 2, number of channels; ≥1.
- ready_THEN_valid_p, 0, 0 = producer may assert v_i regardless of ready; 1 = producer asserts v_i only when ready_param_o is high.
- almost_full_thresh_p, els_p-1, almost_full_o[c] asserts when count ≥ this value.
- Local: ptr_w = max(1,$clog2(els_p)); cnt_w = $clog2(els_p+1); id_w = max(1,$clog2(channels_p)).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- v_i  in  channels_p  per-channel enqueue valid.
- ready_param_o  out  channels_p  per-channel space available.
- data_i  in  channels_p*width_p  per-channel payload; channel c at [c*width_p +: width_p].
- v_o  out  1  output head valid.
- data_o  out  width_p  head payload of the granted channel.
- chan_o  out  id_w  granted channel index.
- yumi_i  in  1  consumer dequeues the current head.
- count_o  out  channels_p*cnt_w  per-channel occupancy.
- almost_full_o  out  channels_p  per-channel threshold flag.

Behaviour:
- Reset (async assert, sync-to-clk deassert done externally):
  - All read/write pointers, counts and grant state clear to 0; the round-robin pointer resets to 0.
  - v_o=0, data_o=0, chan_o=0, count_o=0, almost_full_o=0.
  - ready_param_o is combinationally forced to 0 while reset_n_i=0.
  - Reset mid-operation discards all contents immediately; no partial dequeue completes.
- Enqueue on channel c:
  - enq[c] = v_i[c] & ready_param_o[c], for both modes.
  - Data is written at wptr[c]; wptr wraps from els_p-1 to 0.
  - With ready_THEN_valid_p=1, v_i[c]&~ready_param_o[c] is a protocol error; a simulation assertion fires and no write occurs.
- ready_param_o[c] = ~full[c], from registered state only. A full channel does not accept in the same cycle it is dequeued; ready rises the cycle after.
- No bypass: a word enqueued into an empty channel becomes visible at the output no earlier than the next cycle (1-cycle minimum latency).
- Storage: per-channel register array, read combinationally at rptr.
- Arbitration:
  - With no grant held, grant = first non-empty channel at or after rr_ptr, cyclically.
  - v_o = 1 if any channel is non-empty.
  - Grant is sticky: while v_o & ~yumi_i, chan_o and data_o hold stable even if a higher-priority channel fills.
  - On yumi_i: the granted channel's rptr advances with wrap, its count decrements, rr_ptr ← chan_o+1 (mod channels_p), and the grant is released.
  - Back-to-back yumi on consecutive cycles is supported; each cycle re-arbitrates.
  - yumi_i while v_o=0 is a protocol error; a simulation assertion fires and state is unchanged.
- Simultaneous enqueue and dequeue on the same channel: count unchanged, both pointers advance.
- count_o[c] ranges 0..els_p. full[c] = (count==els_p); empty[c] = (count==0). Both derive from registered counts.
- almost_full_o[c] = (count_o[c] ≥ almost_full_thresh_p), registered-state derived.
- channels_p=1 degenerates to a single small FIFO with chan_o tied to 0.

Test Plan:
- Reset/idle: assert reset_n_i=0 mid-stream with 3 words queued on ch0 → v_o=0, count_o=0 the same cycle, ready_param_o=0. After release, ready_param_o=2'b11 and v_o=0.
- Fill and wrap (els_p=3, channels_p=1): enqueue A,B,C → ready_param_o=0, count=3, almost_full=1. Yumi one → ready returns next cycle. Enqueue D, then drain → output order B,C,D.
- Full with simultaneous yumi (els_p=4): ch0 full, v_i[0]=1 and yumi_i=1 in the same cycle → no enqueue, count 4→3, ready_param_o[0]=1 the following cycle.
- Fairness (channels_p=3): all channels hold 2 words, yumi every cycle → chan_o sequence 0,1,2,0,1,2.
- Sticky grant: only ch2 non-empty, v_o=1, yumi_i=0; ch0 then enqueues → chan_o stays 2 with data_o unchanged until yumi, then chan_o=0.
- Mode/latency: with ready_THEN_valid_p=1, drive v_i while not ready → assertion fires, count unchanged. Enqueue to an empty channel at cycle t → v_o first high at t+1.

Source files
------------

// File: rtl/bsg_fifo_1r1w_small_mc.sv
// Multi-channel small 1r1w FIFO: channels_p independent register-array FIFOs
// draining through one round-robin arbitrated valid/yumi port with a sticky grant.
module bsg_fifo_1r1w_small_mc #(
  parameter int width_p              = 16,
  parameter int els_p                = 4,
  parameter int channels_p           = 2,
  parameter bit ready_THEN_valid_p   = 1'b0,
  parameter int almost_full_thresh_p = els_p - 1,
  localparam int ptr_w = (els_p > 2) ? $clog2(els_p) : 1,
  localparam int cnt_w = $clog2(els_p + 1),
  localparam int id_w  = (channels_p > 2) ? $clog2(channels_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [channels_p-1:0]         v_i,
  output logic [channels_p-1:0]         ready_param_o,
  input  logic [channels_p*width_p-1:0] data_i,
  output logic                          v_o,
  output logic [width_p-1:0]            data_o,
  output logic [id_w-1:0]               chan_o,
  input  logic                          yumi_i,
  output logic [channels_p*cnt_w-1:0]   count_o,
  output logic [channels_p-1:0]         almost_full_o
);

  logic [width_p-1:0]    mem  [channels_p][els_p];
  logic [ptr_w-1:0]      wptr [channels_p];
  logic [ptr_w-1:0]      rptr [channels_p];
  logic [cnt_w-1:0]      cnt  [channels_p];
  logic [channels_p-1:0] full, empty, enq, deq;
  logic [id_w-1:0]       rr_ptr, held_chan, arb_chan, grant, idx;
  logic                  held, found, yumi_ok;

  // Every status flag is a function of the registered counts only.
  always_comb begin
    full          = '0;
    empty         = '0;
    almost_full_o = '0;
    count_o       = '0;
    for (int c = 0; c < channels_p; c++) begin
      full[c]          = (cnt[c] == cnt_w'(els_p));
      empty[c]         = (cnt[c] == '0);
      almost_full_o[c] = (cnt[c] >= cnt_w'(almost_full_thresh_p));
      count_o[c*cnt_w +: cnt_w] = cnt[c];
    end
  end

  assign ready_param_o = reset_n_i ? ~full : '0;
  assign enq           = v_i & ready_param_o;
  assign v_o           = ~&empty;

  // First non-empty channel at or after rr_ptr, searched cyclically.
  always_comb begin
    arb_chan = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < channels_p; k++) begin
      idx = id_w'((int'(rr_ptr) + k) % channels_p);
      if (!found && !empty[idx]) begin
        found    = 1'b1;
        arb_chan = idx;
      end
    end
  end

  assign grant   = held ? held_chan : arb_chan;
  assign chan_o  = v_o ? grant : '0;
  assign data_o  = v_o ? mem[grant][rptr[grant]] : '0;
  assign yumi_ok = yumi_i & v_o;

  always_comb begin
    deq = '0;
    for (int c = 0; c < channels_p; c++) begin
      deq[c] = yumi_ok && (grant == id_w'(c));
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < channels_p; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < channels_p; c++) begin
        if (enq[c]) wptr[c] <= (wptr[c] == ptr_w'(els_p - 1)) ? '0 : wptr[c] + 1'b1;
        if (deq[c]) rptr[c] <= (rptr[c] == ptr_w'(els_p - 1)) ? '0 : rptr[c] + 1'b1;
        if (enq[c] && !deq[c])      cnt[c] <= cnt[c] + 1'b1;
        else if (!enq[c] && deq[c]) cnt[c] <= cnt[c] - 1'b1;
      end
    end
  end

  // The grant is latched while the head is offered but not taken, so the
  // consumer never sees chan_o/data_o change under a pending valid.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      held      <= 1'b0;
      held_chan <= '0;
      rr_ptr    <= '0;
    end else if (yumi_ok) begin
      held   <= 1'b0;
      rr_ptr <= (grant == id_w'(channels_p - 1)) ? '0 : grant + 1'b1;
    end else begin
      held      <= v_o;
      held_chan <= grant;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < channels_p; c++) begin
      if (enq[c]) mem[c][wptr[c]] <= data_i[c*width_p +: width_p];
    end
  end

  a_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

  if (ready_THEN_valid_p) begin : g_rtv
    a_valid_needs_ready: assert property (
      @(posedge clk_i) disable iff (!reset_n_i) (v_i & ~ready_param_o) == '0);
  end

endmodule
